// File: rtl/chip_link_slave.sv
// Chip-side endpoint of the FPGA-to-chip pin link.
// Load transactions write host data into a local 128-bit-wide buffer.
// Store transactions stream buffer words back to the host.
// In dual-rate mode each 128-bit word crosses the pins as two 64-bit halves, low half first.
module chip_link_slave #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         single_rate,
  input  logic         start,
  input  logic         load_or_store,
  input  logic         store_byte4,
  input  logic [11:0]  axaddr_and_axlen,
  input  logic         axvalid,
  output logic         axready,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         data_oe,
  input  logic         rready_or_wvalid,
  output logic         rvalid_or_wready,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLoad,
    StFetch,
    StStore,
    StDone
  } state_e;

  state_e          state_q;
  logic [127:0]    mem [DEPTH];
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_inc;
  logic [3:0]      remaining_q;
  logic            byte4_q;
  logic            single_q;
  logic            half_q;     // first half of a dual-rate word already transferred
  logic [63:0]     low_q;      // low half of a dual-rate load word
  logic [127:0]    word_q;     // current store word, already masked
  logic            w_hs;
  logic            word_done;
  logic [127:0]    rd_word;
  logic [127:0]    rd_next;
  logic            mem_we;
  logic [127:0]    mem_wdata;

  function automatic logic [127:0] mask_word(input logic [127:0] w, input logic b4);
    return b4 ? {96'd0, w[31:0]} : w;
  endfunction

  assign ptr_inc   = ptr_q + AW'(1);
  assign w_hs      = (state_q == StLoad) & rready_or_wvalid & rvalid_or_wready;
  // A handshake completes a full word in single-rate, or on the second half in dual-rate.
  assign word_done = single_q | half_q;
  // The next word is read ahead so a store streams with no bubble between words.
  assign rd_word   = mask_word(mem[ptr_q], byte4_q);
  assign rd_next   = mask_word(mem[ptr_inc], byte4_q);

  // Buffer write strobe and data for load handshakes.
  always_comb begin
    mem_we    = w_hs & word_done;
    mem_wdata = single_q ? data_in : {data_in[63:0], low_q};
  end

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  // Transaction FSM with all link outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      axready          <= 1'b0;
      rvalid_or_wready <= 1'b0;
      data_oe          <= 1'b0;
      done             <= 1'b0;
      busy             <= 1'b0;
      data_out         <= '0;
      ptr_q            <= '0;
      remaining_q      <= '0;
      byte4_q          <= 1'b0;
      single_q         <= 1'b1;
      half_q           <= 1'b0;
      low_q            <= '0;
      word_q           <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAddr;
            axready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StAddr: begin
          // axready is always high here, so axvalid alone completes the handshake.
          if (axvalid) begin
            axready     <= 1'b0;
            ptr_q       <= axaddr_and_axlen[AW-1:0];
            remaining_q <= axaddr_and_axlen[11:8];
            byte4_q     <= store_byte4;
            single_q    <= single_rate;
            half_q      <= 1'b0;
            // Direction is held by the state itself from here on.
            if (load_or_store) begin
              state_q          <= StLoad;
              rvalid_or_wready <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StLoad: begin
          if (rready_or_wvalid) begin
            if (!word_done) begin
              low_q  <= data_in[63:0];
              half_q <= 1'b1;
            end else begin
              half_q <= 1'b0;
              ptr_q  <= ptr_inc;
              if (remaining_q == 4'd0) begin
                state_q          <= StDone;
                rvalid_or_wready <= 1'b0;
                done             <= 1'b1;
              end else begin
                remaining_q <= remaining_q - 4'd1;
              end
            end
          end
        end
        StFetch: begin
          word_q           <= rd_word;
          data_out         <= single_q ? rd_word : {64'd0, rd_word[63:0]};
          half_q           <= 1'b0;
          state_q          <= StStore;
          rvalid_or_wready <= 1'b1;
          data_oe          <= 1'b1;
        end
        StStore: begin
          if (rready_or_wvalid) begin
            if (!word_done) begin
              half_q   <= 1'b1;
              data_out <= {64'd0, word_q[127:64]};
            end else begin
              half_q <= 1'b0;
              if (remaining_q == 4'd0) begin
                state_q          <= StDone;
                rvalid_or_wready <= 1'b0;
                data_oe          <= 1'b0;
                data_out         <= '0;
                done             <= 1'b1;
              end else begin
                remaining_q <= remaining_q - 4'd1;
                ptr_q       <= ptr_inc;
                word_q      <= rd_next;
                data_out    <= single_q ? rd_next : {64'd0, rd_next[63:0]};
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/chip_link_slave.md
Name: chip_link_slave

Overview:
- Chip-side endpoint of the FPGA-to-chip pin link; sits directly downstream of the host-side link driver.
- Consumes the command pins (start, address/length, direction) and the data handshake pins.
- Holds a local 128-bit-wide buffer: load transactions write host data into it, store transactions return buffer data to the host.
- Used as the loopback target in board bring-up.

Parameters:
- DEPTH, 256, buffer entries of 128 bits; power of two, ≤ 256.
- AW, 8, buffer address width = log2(DEPTH).

Ports:
- clk  in  1  link clock.
- rst  in  1  synchronous reset, active-high.
- single_rate  in  1  1: one 128-bit word per handshake; 0: two 64-bit halves per word, low half first.
- start  in  1  one-cycle pulse that opens a transaction.
- load_or_store  in  1  sampled at the address handshake; 1 = load (host→chip), 0 = store (chip→host).
- store_byte4  in  1  sampled at the address handshake; store returns only bits [31:0], upper bits forced to 0.
- axaddr_and_axlen  in  12  {len[3:0], addr[7:0]}; beats = len+1.
- axvalid  in  1  command valid.
- axready  out  1  command ready.
- data_in  in  128  load data; in dual-rate only [63:0] is used.
- data_out  out  128  store data; in dual-rate the half is on [63:0] and [127:64] = 0.
- data_oe  out  1  1 while the chip drives data_out.
- rready_or_wvalid  in  1  wvalid in load, rready in store.
- rvalid_or_wready  out  1  wready in load, rvalid in store.
- done  out  1  one-cycle pulse after the last beat.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset: state=IDLE. axready, rvalid_or_wready, data_oe, done and busy are 0; data_out=0. Buffer contents are not reset.
- States: IDLE, ADDR, LOAD, FETCH, STORE, DONE.
- IDLE: start=1 → ADDR next cycle. A start outside IDLE is ignored.
- ADDR: axready=1.
  - On axvalid&axready, capture ptr=addr[AW-1:0], remaining=len, and latch dir, store_byte4 and single_rate.
  - dir=1 → LOAD; dir=0 → FETCH.
- LOAD: rvalid_or_wready=1 (wready).
  - Single-rate: each cycle with wvalid=1 writes mem[ptr]=data_in.
  - Dual-rate: the first handshake stores data_in[63:0] into a low-half register. The second writes mem[ptr]={data_in[63:0], low}.
  - After each full word: ptr=ptr+1 (mod DEPTH, wraps DEPTH-1→0). If remaining=0 → DONE, else remaining--.
- FETCH: one cycle; read mem[ptr] into a 128-bit output register (masked to [31:0] if store_byte4) → STORE.
- STORE: data_oe=1, rvalid_or_wready=1 (rvalid), data_out holds the current word or half.
  - Data holds stable while rvalid=1 and rready=0.
  - Single-rate: on rready, advance ptr. Last word → DONE; otherwise the next word must be presented with no bubble, so the read of ptr+1 is pipelined.
  - Dual-rate: the first rready presents the high half; the second completes the word.
  - Throughput: 1 handshake/cycle with rready held high.
- DONE: done=1 for one cycle, data_oe=0 → IDLE.
- Read-during-write to the same address cannot occur (direction is exclusive per transaction).
- Simultaneous axvalid and start while in IDLE: start is honoured; axvalid is taken in ADDR on the following cycle if still asserted.
- rst mid-transaction: return to IDLE at the next edge, outputs to reset values, partial dual-rate half discarded. Buffer words already written are retained.
- Handshake pins from the host are registered nowhere inside; the host meets setup to clk.

Test Plan:
- Single-rate load: start; addr=0x10, len=3, load; words 0xA0..0xA3 with wvalid held high → 4 wready handshakes, done pulses exactly 1 cycle after the 4th, mem[0x10..0x13]=A0..A3.
- Single-rate store of same region: addr=0x10, len=3, rready=1 → first rvalid 2 cycles after axvalid handshake, data_out=A0,A1,A2,A3 on consecutive cycles, then done, data_oe drops.
- Backpressure: store with rready toggling 1,0,0,1,... → data_out stable while rready=0, no word skipped or repeated.
- Wrap: load addr=0xFE, len=3 → writes mem[0xFE],[0xFF],[0x00],[0x01]; store readback matches.
- Dual-rate + byte4: load 1 word as halves 0x1111.., 0x2222.. → word {2222..,1111..}. Store with store_byte4=1 → halves low 0x0000_0000_1111_1111-equivalent masked value, high = 0.
- Reset mid-store after 2 of 4 beats → next cycle IDLE, rvalid=0, data_oe=0, no done pulse; new transaction then runs normally.
